frame_config_ctrl: RTL and testbench
====================================

# frame_config_ctrl

Configuration frame writer for the fabric's frame-based configuration network. It accepts a 32-bit command/data word stream and assembles one full configuration frame across all rows into the global FrameData bus. It then pulses exactly one FrameStrobe line, selected by column and frame index, for a fixed number of cycles. It sits between the bitstream source (UART/SPI front end) and the FrameData/FrameStrobe inputs of the tile array, where terminal and fabric tiles buffer and forward these signals.

## Interface
- FrameBitsPerRow, 32, width of one row slice of FrameData; also the stream word width
- NumRows, 16, number of tile rows, i.e. the number of row slices in FrameData
- NumColumns, 8, number of tile columns driven
- MaxFramesPerCol, 20, number of strobe lines per column
- StrobeCycles, 2, number of cycles each strobe is held high (≥1)
- CLK  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- s_data  in  FrameBitsPerRow  command/data word
- s_valid  in  1  word valid
- s_ready  out  1  word accepted when s_valid && s_ready
- FrameData  out  NumRows*FrameBitsPerRow  row slices; row r occupies bits [r*32+31 : r*32]
- FrameStrobe  out  NumColumns*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f
- busy  out  1  state ≠ IDLE
- err  out  1  sticky error flag; cleared only by reset
- frames_written  out  16  count of strobed frames; wraps from 0xFFFF to 0

## Operation
- Command word fields: [31:24] opcode, [23:16] column, [15:8] frame, [7:0] ignored. Opcode WRITE = 0xA5.
- IDLE: s_ready=1.
  - Accepted WRITE with column<NumColumns and frame<MaxFramesPerCol: latch column/frame, clear row_cnt, go to LOAD.
  - WRITE with column or frame out of range: set err, go to DRAIN.
  - Any other opcode: set err, stay in IDLE. That word only is consumed.
- LOAD: s_ready=1. Each accepted word writes FrameData row slice row_cnt, then row_cnt increments. Row 0 is loaded first. On acceptance of row NumRows-1, go to STROBE.
- STROBE: s_ready=0. The selected FrameStrobe bit is high for StrobeCycles cycles; all other bits are 0. FrameData is held constant. On the last strobe cycle, increment frames_written and go to IDLE.
- DRAIN: s_ready=1. Accept and discard NumRows words. FrameData and FrameStrobe are untouched. After the last word, go to IDLE.
- FrameData changes only in LOAD and retains its last value afterwards. FrameStrobe is 0 in every state except STROBE.
- s_valid low in LOAD/DRAIN stalls the block indefinitely. There is no timeout.

## Timing
- Reset, sampled on a CLK edge with resetn=0: state=IDLE, FrameData=0, FrameStrobe=0, err=0, frames_written=0, row_cnt=0, busy=0. s_ready=1 from the first cycle after reset.
- Reset mid-LOAD or mid-STROBE aborts immediately. The strobe drops on the next edge, and no partial-frame strobe ever follows.
- s_ready is combinational from state only and never depends on s_valid.
- A row slice is visible on FrameData the cycle after its handshake.
- The strobe rises the cycle after the last row handshake and stays high cycles 1..StrobeCycles after it. s_ready returns to 1 in the cycle after the strobe falls.
- Minimum frame time with s_valid held high: 1 + NumRows + StrobeCycles cycles (19 with defaults). Back-to-back commands have no extra idle cycle.
- busy is high from the cycle after command acceptance until the return to IDLE.

## Structure
- Shared package frame_cfg_pkg:
  - OPC_WRITE constant (0xA5)
  - command field bit positions
  - state enum {IDLE, LOAD, STROBE, DRAIN}
- One sub-module, frame_strobe_decode: combinational column/frame → one-hot FrameStrobe with enable, plus the range-check outputs.
- Counters:
  - row_cnt: $clog2(NumRows) bits
  - strobe_cnt: $clog2(StrobeCycles+1) bits

## Test plan
- Reset, then WRITE 0xA5_03_05_00 followed by 16 words 0x1000+r with s_valid always high. Expect:
  - FrameData row r = 0x1000+r
  - FrameStrobe bit 65 high for exactly 2 cycles, starting 1 cycle after the 16th handshake
  - frames_written=1, err=0
- Random s_valid gaps during LOAD. Expect s_ready held high, rows written only on handshakes, and the same final FrameData as the ungapped case.
- WRITE with column=8 (out of range), then 16 words, then a valid WRITE. Expect:
  - err=1, no strobe for the bad command, FrameData unchanged
  - the second frame strobes normally
- Opcode 0x00 word. Expect one-word consumption, err=1, state stays IDLE, no strobe.
- Assert resetn=0 after 7 LOAD words. Expect:
  - all outputs zero and no strobe afterwards
  - a following full frame works normally
- Drive 0xFFFF frames via a forced counter preload, then one more frame. Expect frames_written to wrap to 0.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the configuration frame writer: command word layout,
// opcode values and the controller state encoding.
package frame_cfg_pkg;

    localparam logic [7:0] OPC_WRITE = 8'hA5;

    // Command word layout: [31:24] opcode, [23:16] column, [15:8] frame, [7:0] unused
    localparam int OPC_LSB = 24;
    localparam int COL_LSB = 16;
    localparam int FRM_LSB = 8;
    localparam int FIELD_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Extract one 8-bit field from a command word
    function automatic logic [FIELD_W-1:0] cmd_field(input logic [31:0] word, input int lsb);
        return word[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/frame_config_ctrl_decode.sv
// Column/frame decoder: one-hot strobe vector gated by an enable, plus range
// checks of the same column/frame against the array dimensions.
module frame_strobe_decode #(
    parameter int NumColumns      = 8,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [7:0]                              column,
    input  logic [7:0]                              frame,
    input  logic                                    enable,
    output logic [NumColumns*MaxFramesPerCol-1:0]   strobe,
    output logic                                    col_ok,
    output logic                                    frm_ok
);

    assign col_ok = int'(column) < NumColumns;
    assign frm_ok = int'(frame) < MaxFramesPerCol;

    // One comparator per strobe line; bit c*MaxFramesPerCol+f belongs to column c, frame f
    generate
        for (genvar gi = 0; gi < NumColumns; gi++) begin : g_col
            for (genvar gj = 0; gj < MaxFramesPerCol; gj++) begin : g_frm
                assign strobe[gi*MaxFramesPerCol+gj] =
                    enable && (int'(column) == gi) && (int'(frame) == gj);
            end
        end
    endgenerate

endmodule

// File: rtl/frame_config_ctrl.sv
// Configuration frame writer: takes a WRITE command followed by one word per
// row, assembles the frame on FrameData, then pulses the selected FrameStrobe
// line for a fixed number of cycles. Bad commands set a sticky error flag.
module frame_config_ctrl
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 16,
    parameter int NumColumns      = 8,
    parameter int MaxFramesPerCol = 20,
    parameter int StrobeCycles    = 2
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [FrameBitsPerRow-1:0]              s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]      FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                    busy,
    output logic                                    err,
    output logic [15:0]                             frames_written
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int STB_W = $clog2(StrobeCycles + 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NumRows - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(StrobeCycles - 1);

    state_t                     state_reg, state_next;
    logic [ROW_W-1:0]           row_cnt_reg;
    logic [STB_W-1:0]           strobe_cnt_reg;
    logic [7:0]                 col_reg, frm_reg;
    logic                       err_reg;
    logic [15:0]                frames_cnt_reg;
    logic [FrameBitsPerRow-1:0] frame_data_reg [NumRows];

    logic [7:0] cmd_opc, cmd_col, cmd_frm;
    logic [7:0] dec_col, dec_frm;
    logic       col_ok, frm_ok;
    logic       cmd_accept, cmd_bad, row_write, drain_word, strobe_done;

    assign cmd_opc = cmd_field(s_data[31:0], OPC_LSB);
    assign cmd_col = cmd_field(s_data[31:0], COL_LSB);
    assign cmd_frm = cmd_field(s_data[31:0], FRM_LSB);

    // The decoder range-checks the incoming command while idle and decodes
    // the latched target otherwise, so one instance serves both purposes.
    assign dec_col = (state_reg == IDLE) ? cmd_col : col_reg;
    assign dec_frm = (state_reg == IDLE) ? cmd_frm : frm_reg;

    frame_strobe_decode #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_decode (
        .column (dec_col),
        .frame  (dec_frm),
        .enable (state_reg == STROBE),
        .strobe (FrameStrobe),
        .col_ok (col_ok),
        .frm_ok (frm_ok)
    );

    // Next-state logic; s_ready depends on the current state only
    always_comb begin
        state_next  = state_reg;
        s_ready     = 1'b0;
        cmd_accept  = 1'b0;
        cmd_bad     = 1'b0;
        row_write   = 1'b0;
        drain_word  = 1'b0;
        strobe_done = 1'b0;
        case (state_reg)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (cmd_opc == OPC_WRITE && col_ok && frm_ok) begin
                        cmd_accept = 1'b1;
                        state_next = LOAD;
                    end else begin
                        cmd_bad = 1'b1;
                        // A malformed WRITE still carries a payload that must be swallowed
                        if (cmd_opc == OPC_WRITE) state_next = DRAIN;
                    end
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    row_write = 1'b1;
                    if (row_cnt_reg == ROW_LAST) state_next = STROBE;
                end
            end
            STROBE: begin
                if (strobe_cnt_reg == STB_LAST) begin
                    strobe_done = 1'b1;
                    state_next  = IDLE;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    drain_word = 1'b1;
                    if (row_cnt_reg == ROW_LAST) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Row/strobe counters, latched target, error flag and frame counter
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            row_cnt_reg    <= '0;
            strobe_cnt_reg <= '0;
            col_reg        <= '0;
            frm_reg        <= '0;
            err_reg        <= 1'b0;
            frames_cnt_reg <= '0;
        end else begin
            if (cmd_accept) begin
                col_reg <= cmd_col;
                frm_reg <= cmd_frm;
            end
            if (cmd_accept || cmd_bad)
                row_cnt_reg <= '0;
            else if (row_write || drain_word)
                row_cnt_reg <= (row_cnt_reg == ROW_LAST) ? '0 : row_cnt_reg + 1'b1;
            if (cmd_bad)
                err_reg <= 1'b1;
            if (state_reg == STROBE)
                strobe_cnt_reg <= strobe_done ? '0 : strobe_cnt_reg + 1'b1;
            else
                strobe_cnt_reg <= '0;
            if (strobe_done)
                frames_cnt_reg <= frames_cnt_reg + 16'd1;
        end
    end

    // Row slice storage; written only by LOAD handshakes, held otherwise
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            for (int i = 0; i < NumRows; i++) frame_data_reg[i] <= '0;
        end else if (row_write) begin
            frame_data_reg[row_cnt_reg] <= s_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NumRows; gi++) begin : g_row
            assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = frame_data_reg[gi];
        end
    endgenerate

    assign busy           = (state_reg != IDLE);
    assign err            = err_reg;
    assign frames_written = frames_cnt_reg;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Scoreboard bench for frame_config_ctrl: stimulus pushes expected strobe
// events and status snapshots into queues; a negedge monitor pops and compares.
module tb_frame_config_ctrl;

    localparam int NR = 16;
    localparam int W  = 32;
    localparam int NC = 8;
    localparam int MF = 20;
    localparam int SC = 2;

    localparam int K_STATUS  = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_END     = 2;

    typedef logic [NR*W-1:0] wide_t;

    typedef struct {
        int          kind;
        string       name;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_err;
        logic [15:0] exp_fw;
        wide_t       exp_data;
    } stat_t;

    typedef struct {
        int          bit_idx;
        wide_t       data;
        logic [15:0] fw;
        logic        err;
        longint      start;
    } frm_t;

    logic               CLK = 1'b0;
    logic               resetn;
    logic [W-1:0]       s_data;
    logic               s_valid;
    logic               s_ready;
    logic [NR*W-1:0]    FrameData;
    logic [NC*MF-1:0]   FrameStrobe;
    logic               busy;
    logic               err;
    logic [15:0]        frames_written;

    always #5 CLK = ~CLK;

    frame_config_ctrl #(
        .FrameBitsPerRow (W),
        .NumRows         (NR),
        .NumColumns      (NC),
        .MaxFramesPerCol (MF),
        .StrobeCycles    (SC)
    ) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .err            (err),
        .frames_written (frames_written)
    );

    stat_t  stat_q[$];
    frm_t   frm_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int               run = 0;
    longint           run_start = 0;
    logic [NC*MF-1:0] run_val = '0;
    logic             run_glitch = 1'b0;

    always @(negedge CLK) begin
        stat_t            st;
        frm_t             f;
        logic [NC*MF-1:0] exp_s;
        while (stat_q.size() > 0) begin
            st = stat_q.pop_front();
            if (st.kind == K_TIMEOUT) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: handshake wait expired, got s_ready=0, expected s_ready=1", st.name);
            end else if (st.kind == K_END) begin
                chk({st.name, "_pending_frames"}, wide_t'(frm_q.size()), wide_t'(0));
                chk({st.name, "_strobe_active"}, wide_t'(run), wide_t'(0));
            end else begin
                chk({st.name, "_s_ready"}, wide_t'(s_ready), wide_t'(st.exp_ready));
                chk({st.name, "_busy"}, wide_t'(busy), wide_t'(st.exp_busy));
                chk({st.name, "_err"}, wide_t'(err), wide_t'(st.exp_err));
                chk({st.name, "_frames_written"}, wide_t'(frames_written), wide_t'(st.exp_fw));
                chk({st.name, "_FrameData"}, FrameData, st.exp_data);
                chk({st.name, "_FrameStrobe"}, wide_t'(FrameStrobe), wide_t'(0));
            end
        end

        if (FrameStrobe != '0) begin
            if (run == 0) begin
                run_start = cyc;
                run_val   = FrameStrobe;
            end else if (FrameStrobe != run_val) begin
                run_glitch = 1'b1;
            end
            run++;
        end else if (run > 0) begin
            if (frm_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe %0h for %0d cycles, expected none", run_val, run);
            end else begin
                f = frm_q.pop_front();
                exp_s = '0;
                exp_s[f.bit_idx] = 1'b1;
                chk("strobe_select", wide_t'(run_val), wide_t'(exp_s));
                chk("strobe_length", wide_t'(run), wide_t'(SC));
                chk("strobe_start_cycle", wide_t'(run_start), wide_t'(f.start));
                chk("strobe_stable", wide_t'(run_glitch), wide_t'(0));
                chk("frame_FrameData", FrameData, f.data);
                chk("frame_frames_written", wide_t'(frames_written), wide_t'(f.fw));
                chk("frame_err", wide_t'(err), wide_t'(f.err));
            end
            run        = 0;
            run_glitch = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    wide_t       model_data;
    logic [15:0] cur_fw;
    logic        cur_err;

    task automatic push_status(input string name, input logic rdy, input logic bsy);
        stat_t st;
        st.kind      = K_STATUS;
        st.name      = name;
        st.exp_ready = rdy;
        st.exp_busy  = bsy;
        st.exp_err   = cur_err;
        st.exp_fw    = cur_fw;
        st.exp_data  = model_data;
        stat_q.push_back(st);
    endtask

    task automatic push_kind(input int kind, input string name);
        stat_t st;
        st.kind      = kind;
        st.name      = name;
        st.exp_ready = 1'b0;
        st.exp_busy  = 1'b0;
        st.exp_err   = 1'b0;
        st.exp_fw    = '0;
        st.exp_data  = '0;
        stat_q.push_back(st);
    endtask

    // Present one word; optional idle gap first (only used inside LOAD)
    task automatic send_word(input logic [W-1:0] w, input int gap, input string name);
        logic acc;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge CLK);
                #1;
            end
            push_status({name, "_gap"}, 1'b1, 1'b1);
        end
        s_valid = 1'b1;
        s_data  = w;
        acc     = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge CLK);
            acc = s_ready;
            @(posedge CLK);
            #1;
        end
        s_valid = 1'b0;
        if (!acc) push_kind(K_TIMEOUT, name);
    endtask

    task automatic send_frame(input logic [7:0] col, input logic [7:0] frm,
                              input logic [W-1:0] base, input int maxgap, input string name);
        frm_t         f;
        logic [W-1:0] w;
        int           g;
        send_word({8'hA5, col, frm, 8'h00}, 0, name);
        push_status({name, "_cmd"}, 1'b1, 1'b1);
        for (int r = 0; r < NR; r++) begin
            w = base + W'(r);
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            send_word(w, g, name);
            model_data[r*W +: W] = w;
        end
        cur_fw    = cur_fw + 16'd1;
        f.bit_idx = int'(col) * MF + int'(frm);
        f.data    = model_data;
        f.fw      = cur_fw;
        f.err     = cur_err;
        f.start   = cyc;
        frm_q.push_back(f);
    endtask

    task automatic bad_cmd(input logic [7:0] col, input logic [7:0] frm, input string name);
        send_word({8'hA5, col, frm, 8'h00}, 0, name);
        cur_err = 1'b1;
        push_status({name, "_drain"}, 1'b1, 1'b1);
        for (int r = 0; r < NR; r++) send_word(32'hDEAD_0000 + W'(r), 0, name);
        push_status({name, "_done"}, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input string name);
        s_valid = 1'b0;
        resetn  = 1'b0;
        @(posedge CLK);
        #1;
        model_data = '0;
        cur_fw     = '0;
        cur_err    = 1'b0;
        push_status(name, 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn     = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        model_data = '0;
        cur_fw     = '0;
        cur_err    = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        do_reset("reset");

        // Basic frame: column 3, frame 5 -> strobe bit 65
        send_frame(8'd3, 8'd5, 32'h1000, 0, "frameA");

        // Unknown opcode: one word consumed, error set, stays idle
        send_word(32'h0000_0000, 0, "opc_bad");
        cur_err = 1'b1;
        push_status("opc_bad", 1'b1, 1'b0);

        // Abort in the middle of LOAD
        send_word({8'hA5, 8'd1, 8'd2, 8'h00}, 0, "abort");
        for (int r = 0; r < 7; r++) begin
            send_word(32'h7700 + W'(r), 0, "abort");
            model_data[r*W +: W] = 32'h7700 + W'(r);
        end
        do_reset("abort_reset");
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        push_status("abort_idle", 1'b1, 1'b0);

        // Out-of-range column and frame: payload drained, no strobe
        bad_cmd(8'd8, 8'd0, "bad_col");
        bad_cmd(8'd0, 8'd20, "bad_frm");

        // Highest strobe line, then lowest with random valid gaps
        send_frame(8'd7, 8'd19, 32'h2000, 0, "frameB");
        send_frame(8'd0, 8'd0, 32'h1000, 3, "frameC");

        // Counter wrap: preload 0xFFFF, then one more frame
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        force dut.frames_cnt_reg = 16'hFFFF;
        #1;
        release dut.frames_cnt_reg;
        cur_fw = 16'hFFFF;
        push_status("preload", 1'b1, 1'b0);
        send_frame(8'd4, 8'd10, 32'h3000, 0, "frameWrap");

        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        push_status("final", 1'b1, 1'b0);
        push_kind(K_END, "end");
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
